// File: rtl/seg_disp_sched_pkg.sv
// Shared display types and constants: FSM encoding, data width, default dwell.
package seg_disp_sched_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned DWELL_DEFAULT = 12_500_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_NEXT = 2'd2
  } state_t;

endpackage

// File: rtl/seg_disp_sched_if.sv
// Source write bus, dwell/pin controls and display outputs of the display scheduler.
interface seg_disp_sched_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DWELL_W = 24
);
  import seg_disp_sched_pkg::*;

  logic [NUM_SRC-1:0]        src_valid;
  logic [DATA_W*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]        src_ready;
  logic [DWELL_W-1:0]        dwell;
  logic                      pin_en;
  logic [SEL_W-1:0]          pin_sel;
  logic [DATA_W-1:0]         num;
  logic [SEL_W-1:0]          cur_src;
  logic                      num_valid;

  modport master (
    output src_valid, src_data, dwell, pin_en, pin_sel,
    input  src_ready, num, cur_src, num_valid
  );

  modport slave (
    input  src_valid, src_data, dwell, pin_en, pin_sel,
    output src_ready, num, cur_src, num_valid
  );

endinterface

// File: rtl/seg_disp_sched_rr_next_sel.sv
// Round-robin pick of the first set mask bit strictly after i_cur, wrapping;
// holds i_cur when no other bit is set.
module rr_next_sel #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SEL_W   = 2
) (
  input  logic [NUM_SRC-1:0] i_mask,
  input  logic [SEL_W-1:0]   i_cur,
  output logic [SEL_W-1:0]   o_next_c,
  output logic               o_found_c
);

  logic [SEL_W-1:0] w_idx;

  // Scan farthest-first so the nearest candidate wins.
  always_comb begin
    o_next_c  = i_cur;
    o_found_c = 1'b0;
    w_idx     = '0;
    for (int k = int'(NUM_SRC) - 1; k >= 1; k--) begin
      w_idx = i_cur + SEL_W'(k);
      if (i_mask[w_idx]) begin
        o_next_c  = w_idx;
        o_found_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_disp_sched.sv
// Multi-source seven-segment display scheduler: per-source slots, dwell-timed
// round-robin rotation with pinning.
module seg_disp_sched
  import seg_disp_sched_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DWELL_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  seg_disp_sched_if.slave   bus
);

  state_t              r_state, w_state_nxt;
  logic [SEL_W-1:0]    r_cur, w_cur_nxt, w_first, w_rr_next;
  logic                w_rr_found;
  logic [DWELL_W-1:0]  r_cnt, w_cnt_nxt, w_lim;
  logic [NUM_SRC-1:0]  r_ready, r_written, w_acc, w_written_nxt;
  logic [DATA_W-1:0]   r_slot [NUM_SRC];
  logic [DATA_W-1:0]   r_num;
  logic                r_num_valid;

  assign w_acc         = bus.src_valid & r_ready;
  assign w_written_nxt = r_written | w_acc;
  assign w_lim         = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);

  // Lowest-indexed accepted write seeds the rotation out of IDLE.
  always_comb begin
    w_first = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (w_acc[i]) w_first = SEL_W'(i);
    end
  end

  rr_next_sel #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_rr (
    .i_mask    (r_written),
    .i_cur     (r_cur),
    .o_next_c  (w_rr_next),
    .o_found_c (w_rr_found)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cur   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Pinning overrides rotation; leaving it resumes SHOW with a zeroed count.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_cnt_nxt   = r_cnt;
    if (bus.pin_en) begin
      w_cur_nxt   = bus.pin_sel;
      w_cnt_nxt   = '0;
      w_state_nxt = (|w_written_nxt) ? ST_SHOW : ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (|w_acc) begin
            w_state_nxt = ST_SHOW;
            w_cur_nxt   = w_first;
            w_cnt_nxt   = '0;
          end
        end
        ST_SHOW: begin
          if (r_cnt >= w_lim) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_NEXT;
          end else begin
            w_cnt_nxt = r_cnt + DWELL_W'(1);
          end
        end
        ST_NEXT: begin
          if (w_rr_found) w_cur_nxt = w_rr_next;
          w_state_nxt = ST_SHOW;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Slot storage and display register; num follows the shown slot one edge later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ready     <= '0;
      r_written   <= '0;
      r_num       <= '0;
      r_num_valid <= 1'b0;
      for (int i = 0; i < int'(NUM_SRC); i++) r_slot[i] <= '0;
    end else begin
      r_ready   <= '1;
      r_written <= w_written_nxt;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (w_acc[i]) r_slot[i] <= bus.src_data[DATA_W*i +: DATA_W];
      end
      r_num       <= r_slot[r_cur];
      r_num_valid <= r_written[r_cur];
    end
  end

  assign bus.src_ready = r_ready;
  assign bus.num       = r_num;
  assign bus.cur_src   = r_cur;
  assign bus.num_valid = r_num_valid;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Directed bench for seg_disp_sched: idle/reset, rotation, single source,
// pinning, zero dwell and mid-rotation reset.
module tb_seg_disp_sched;
  import seg_disp_sched_pkg::*;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned DWELL_W = 24;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  seg_disp_sched_if #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

  seg_disp_sched #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.src_valid = '0;
    bus.src_data  = '0;
    bus.pin_en    = 1'b0;
    bus.pin_sel   = '0;
  endtask

  // Two reset edges, release, then one edge so src_ready is up.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  logic [31:0] exp_num;
  logic [1:0]  exp_cur;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b0;
    clear_inputs();
    bus.dwell = DWELL_W'(DWELL_DEFAULT);

    // Reset state and 100 idle cycles.
    repeat (3) tick();
    chk("rst_num",   64'(bus.num),       64'h0);
    chk("rst_valid", 64'(bus.num_valid), 64'h0);
    chk("rst_cur",   64'(bus.cur_src),   64'h0);
    chk("rst_ready", 64'(bus.src_ready), 64'h0);
    rst = 1'b1;
    tick();
    for (int k = 0; k < 100; k++) begin
      chk("idle_out", 64'({bus.num, bus.num_valid, bus.cur_src}), 64'h0);
      chk("idle_ready", 64'(bus.src_ready), 64'hF);
      tick();
    end

    // Two sources written together, dwell 4: 0,2,0,... with 5-cycle periods.
    do_reset();
    bus.dwell     = 24'd4;
    bus.src_valid = 4'b0101;
    bus.src_data  = {32'h0, 32'hCAFEBABE, 32'h0, 32'h12345678};
    tick();
    bus.src_valid = '0;
    for (int k = 0; k < 20; k++) begin
      exp_cur = (((k / 5) % 2) == 0) ? 2'd0 : 2'd2;
      if (k == 0) exp_num = 32'h0;
      else        exp_num = ((((k - 1) / 5) % 2) == 0) ? 32'h12345678 : 32'hCAFEBABE;
      chk("rot_cur",   64'(bus.cur_src),   64'(exp_cur));
      chk("rot_num",   64'(bus.num),       64'(exp_num));
      chk("rot_valid", 64'(bus.num_valid), (k == 0) ? 64'h0 : 64'h1);
      tick();
    end

    // Single source, dwell 3; rewrite lands on an expiry edge.
    do_reset();
    bus.dwell     = 24'd3;
    bus.src_valid = 4'b0010;
    bus.src_data  = {32'h0, 32'h0, 32'hA5A50001, 32'h0};
    tick();
    bus.src_valid = '0;
    for (int k = 0; k < 20; k++) begin
      if (k == 0)      exp_num = 32'h0;
      else if (k < 12) exp_num = 32'hA5A50001;
      else             exp_num = 32'h0BADF00D;
      chk("one_cur", 64'(bus.cur_src), 64'h1);
      chk("one_num", 64'(bus.num),     64'(exp_num));
      if (k == 10) begin
        bus.src_valid = 4'b0010;
        bus.src_data  = {32'h0, 32'h0, 32'h0BADF00D, 32'h0};
      end else begin
        bus.src_valid = '0;
      end
      tick();
    end

    // Pin an unwritten source, then write it, then release the pin.
    do_reset();
    bus.dwell   = 24'd2;
    bus.pin_en  = 1'b1;
    bus.pin_sel = 2'd3;
    tick();
    chk("pin_cur",   64'(bus.cur_src),   64'h3);
    chk("pin_num0",  64'(bus.num),       64'h0);
    chk("pin_val0",  64'(bus.num_valid), 64'h0);
    repeat (2) tick();
    chk("pin_num0b", 64'(bus.num),       64'h0);
    chk("pin_val0b", 64'(bus.num_valid), 64'h0);
    bus.src_valid = 4'b1010;
    bus.src_data  = {32'hDEADBEEF, 32'h0, 32'h11111111, 32'h0};
    tick();
    bus.src_valid = '0;
    chk("pin_num_acc", 64'(bus.num), 64'h0);
    tick();
    chk("pin_num",   64'(bus.num),       64'hDEADBEEF);
    chk("pin_valid", 64'(bus.num_valid), 64'h1);
    for (int k = 0; k < 5; k++) begin
      chk("pin_hold", 64'(bus.cur_src), 64'h3);
      tick();
    end
    bus.pin_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_cur = (k >= 2 && k <= 4) ? 2'd1 : 2'd3;
      chk("unpin_cur", 64'(bus.cur_src), 64'(exp_cur));
      if (k == 3) chk("unpin_num", 64'(bus.num), 64'h11111111);
    end

    // Zero dwell: each source one cycle plus NEXT; then reset mid-rotation.
    do_reset();
    bus.dwell     = 24'd0;
    bus.src_valid = 4'b0011;
    bus.src_data  = {32'h0, 32'h0, 32'h000000BB, 32'h000000AA};
    tick();
    bus.src_valid = '0;
    for (int k = 0; k < 7; k++) begin
      exp_cur = (((k / 2) % 2) == 0) ? 2'd0 : 2'd1;
      chk("d0_cur", 64'(bus.cur_src), 64'(exp_cur));
      tick();
    end
    rst = 1'b0;
    tick();
    chk("mid_rst", 64'({bus.num, bus.num_valid, bus.cur_src, bus.src_ready}), 64'h0);
    rst = 1'b1;
    tick();
    chk("post_rst_ready", 64'(bus.src_ready), 64'hF);
    repeat (3) tick();
    chk("post_rst_idle", 64'({bus.num, bus.num_valid, bus.cur_src}), 64'h0);
    bus.src_valid = 4'b0100;
    bus.src_data  = {32'h0, 32'h00000022, 32'h0, 32'h0};
    tick();
    bus.src_valid = '0;
    chk("restart_cur", 64'(bus.cur_src), 64'h2);
    tick();
    chk("restart_num",   64'(bus.num),       64'h22);
    chk("restart_valid", 64'(bus.num_valid), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
